// File: rtl/pipe_stage_skid_pkg.sv
// pipe_stage_skid_pkg: occupancy states and the stage bundle widths/NOP encodings shared by the pipeline.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 146;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;

    // ID/EX control bits sit at the bottom of the bundle
    localparam int ID_EX_PL = 0;
    localparam int ID_EX_RW = 1;
    localparam int ID_EX_MW = 2;
    localparam int ID_EX_MR = 3;

    localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = '0;
    localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = ID_EX_W'(1) << ID_EX_PL;
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;
    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = '0;

    function automatic logic [1:0] occ_count(input occ_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// pipe_stage_skid_sat_counter: up-counter that sticks at its maximum value.
module pipe_stage_skid_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: registered valid/ready pipeline stage with a 2-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int               WIDTH  = 146,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    occ_e             state, state_n;
    logic [WIDTH-1:0] main_q, main_n, skid_q, skid_n;
    logic             accept, consume;

    assign out_valid = state != EMPTY;
    assign out_data  = main_q;
    assign occupancy = occ_count(state);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            main_q   <= BUBBLE;
            skid_q   <= BUBBLE;
            in_ready <= 1'b1;
        end else begin
            state    <= state_n;
            main_q   <= main_n;
            skid_q   <= skid_n;
            in_ready <= state_n != FULL;
        end
    end

    // flush wins over everything; an output transfer in the same cycle still counts downstream
    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = BUBBLE;
            skid_n  = BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n = ONE;
                        main_n  = in_data;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_n = in_data;
                    end else if (accept) begin
                        state_n = FULL;
                        skid_n  = in_data;
                    end else if (consume) begin
                        state_n = EMPTY;
                        main_n  = BUBBLE;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_n = ONE;
                        main_n  = skid_q;
                        skid_n  = BUBBLE;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = BUBBLE;
                    skid_n  = BUBBLE;
                end
            endcase
        end
    end

    pipe_stage_skid_sat_counter #(.CNT_W(CNT_W)) u_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of streaming, back-pressure, flush, async reset and counter saturation.
module tb_pipe_stage_skid;

    localparam int W = 146;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid, sat_in_ready, sat_out_valid;
    logic [W-1:0] out_data, sat_out_data;
    logic [1:0]   occupancy, sat_occupancy;
    logic [15:0]  stall_cnt;
    logic [3:0]   sat_stall_cnt;
    int           total = 0;
    int           passed = 0;

    pipe_stage_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
        .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_idle(input string tag, input int stall);
        chkn({tag, "_valid"}, int'(out_valid), 0);
        chkn({tag, "_ready"}, int'(in_ready), 1);
        chkn({tag, "_occ"}, int'(occupancy), 0);
        chkn({tag, "_stall"}, int'(stall_cnt), stall);
        chk({tag, "_data"}, out_data, '0);
    endtask

    initial begin
        tick();
        chk_idle("reset", 0);
        rst = 1'b1;
        // streaming: one-cycle latency, no gaps
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = W'(i);
            tick();
            chk("stream_data", out_data, W'(i));
            chkn("stream_occ", int'(occupancy), 1);
            chkn("stream_ready", int'(in_ready), 1);
        end
        in_valid = 1'b0;
        tick();
        chk_idle("stream_drain", 0);
        // back-pressure with A, B, C
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('hA);
        tick();
        chk("bp_a", out_data, W'('hA));
        chkn("bp_a_stall", int'(stall_cnt), 0);
        in_data = W'('hB);
        tick();
        chkn("bp_full_occ", int'(occupancy), 2);
        chkn("bp_full_ready", int'(in_ready), 0);
        chk("bp_full_data", out_data, W'('hA));
        in_data = W'('hC);
        tick();
        chkn("bp_hold_occ", int'(occupancy), 2);
        chk("bp_hold_data", out_data, W'('hA));
        chkn("bp_hold_stall", int'(stall_cnt), 2);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", out_data, W'('hB));
        chkn("bp_out_b_occ", int'(occupancy), 1);
        chkn("bp_out_b_ready", int'(in_ready), 1);
        tick();
        chk("bp_out_c", out_data, W'('hC));
        in_valid = 1'b0;
        tick();
        chk_idle("bp_drain", 2);
        // flush from FULL with D offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('h11);
        tick();
        in_data = W'('h22);
        tick();
        chkn("fl_full_occ", int'(occupancy), 2);
        flush   = 1'b1;
        in_data = W'('hDD);
        tick();
        chk_idle("fl_full", 4);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk_idle("fl_full_after", 4);
        // flush from ONE drops an accepted D
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = W'('h33);
        tick();
        chk("fl_one_data", out_data, W'('h33));
        flush   = 1'b1;
        in_data = W'('hDD);
        tick();
        chk_idle("fl_one", 4);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk_idle("fl_one_after", 4);
        // asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W'('h44);
        tick();
        in_data = W'('h55);
        tick();
        chkn("rst_full_occ", int'(occupancy), 2);
        chkn("rst_full_stall", int'(stall_cnt), 5);
        rst = 1'b0;
        #2;
        chk_idle("rst_async", 0);
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        chk_idle("rst_release", 0);
        // saturation: 16-bit keeps counting, 4-bit sticks at 15
        in_valid = 1'b1;
        in_data  = W'('h66);
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        chkn("sat_14", int'(sat_stall_cnt), 14);
        tick();
        chkn("sat_15", int'(sat_stall_cnt), 15);
        repeat (5) tick();
        chkn("sat_hold", int'(sat_stall_cnt), 15);
        chkn("sat_wide", int'(stall_cnt), 20);
        chk("sat_data", out_data, W'('h66));
        chkn("sat_occ", int'(occupancy), 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
